// File: rtl/trace_replay_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trace_replay_pkg
//  Brief    : Shared types and widths for the trace replay driver.
//  Revision : 1.0
// ============================================================================
package trace_replay_pkg;

    localparam int c_NUM_INPUTS = 2;
    localparam int c_DATA_W     = 64;
    localparam int c_DELAY_W    = 16;
    localparam int c_DEPTH      = 32;
    localparam int c_CNT_W      = 32;

    localparam int c_ADDR_W     = $clog2(c_DEPTH);
    localparam int c_LEN_W      = c_ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_FIRE  = 2'd3
    } state_e;

    // Field order fixes the packed layout: delay in the MSBs, data in the LSBs.
    typedef struct packed {
        logic [c_DELAY_W-1:0]             delay;
        logic [c_NUM_INPUTS-1:0]          mask;
        logic [c_NUM_INPUTS*c_DATA_W-1:0] data;
    } entry_t;

    localparam int c_ENTRY_W = $bits(entry_t);

    function automatic int entry_width(input int num_inputs, input int data_w, input int delay_w);
        return delay_w + num_inputs + num_inputs * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_replay_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : trace_replay_driver_if
//  Brief    : Loader write bus and monitor input bus of the replay driver.
//  Revision : 1.0
// ============================================================================
interface trace_replay_driver_if #(
    parameter int NUM_INPUTS = 2,
    parameter int DATA_W     = 64,
    parameter int DELAY_W    = 16,
    parameter int DEPTH      = 32
) ();

    logic                         wr_en;
    logic [$clog2(DEPTH)-1:0]     wr_addr;
    logic [DELAY_W-1:0]           wr_delay;
    logic [NUM_INPUTS-1:0]        wr_mask;
    logic [NUM_INPUTS*DATA_W-1:0] wr_data;
    logic                         wr_err;
    logic [NUM_INPUTS*DATA_W-1:0] input_data;
    logic [NUM_INPUTS-1:0]        new_input;

    modport master (
        output wr_en, wr_addr, wr_delay, wr_mask, wr_data,
        input  wr_err, input_data, new_input
    );

    modport slave (
        input  wr_en, wr_addr, wr_delay, wr_mask, wr_data,
        output wr_err, input_data, new_input
    );

endinterface
`default_nettype wire

// File: rtl/trace_replay_driver_trace_mem.sv
`default_nettype none
// ============================================================================
//  Module   : trace_mem
//  Brief    : Single-write / single-read synchronous trace RAM (no reset).
//  Revision : 1.0
// ============================================================================
module trace_mem #(
    parameter int WIDTH = 82,
    parameter int DEPTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]         i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic      [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;
    logic [WIDTH-1:0] w_rdata_d;

    always_comb begin
        w_rdata_d = r_mem_q[i_raddr];
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        r_rdata_q <= w_rdata_d;
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/trace_replay_driver.sv
`default_nettype none
// ============================================================================
//  Module   : trace_replay_driver
//  Brief    : Replays a stored timed event trace into RTLola monitor inputs.
//  Revision : 1.0
// ============================================================================
module trace_replay_driver
    import trace_replay_pkg::*;
#(
    parameter int NUM_INPUTS = c_NUM_INPUTS,
    parameter int DATA_W     = c_DATA_W,
    parameter int DELAY_W    = c_DELAY_W,
    parameter int DEPTH      = c_DEPTH,
    parameter int CNT_W      = c_CNT_W
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    trace_replay_driver_if.slave          bus,
    input  wire logic [$clog2(DEPTH):0]   num_entries,
    input  wire logic                     loop,
    input  wire logic                     start,
    input  wire logic                     stop,
    input  wire logic                     hold,
    output logic                          busy,
    output logic                          done,
    output logic      [$clog2(DEPTH)-1:0] entry_idx,
    output logic      [CNT_W-1:0]         cycle_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_DW = NUM_INPUTS * DATA_W;
    localparam int c_EW = entry_width(NUM_INPUTS, DATA_W, DELAY_W);
    localparam logic [c_LW-1:0]    c_DEPTH_LEN = c_LW'(DEPTH);
    localparam logic [DELAY_W-1:0] c_ONE       = DELAY_W'(1);

    state_e                r_state_q,  w_state_d;
    logic [c_AW-1:0]       r_idx_q,    w_idx_d;
    logic [c_LW-1:0]       r_len_q,    w_len_d;
    logic                  r_loop_q,   w_loop_d;
    logic [DELAY_W-1:0]    r_cnt_q,    w_cnt_d;
    logic                  r_cnt_ld_q, w_cnt_ld_d;
    logic [NUM_INPUTS-1:0] r_new_q,    w_new_d;
    logic [c_DW-1:0]       r_data_q,   w_data_d;
    logic                  r_done_q,   w_done_d;
    logic                  r_wr_err_q, w_wr_err_d;
    logic [CNT_W-1:0]      r_ccnt_q,   w_ccnt_d;

    logic                  w_mem_we;
    logic [c_EW-1:0]       w_wr_entry;
    logic [c_EW-1:0]       w_rd_entry;
    logic [DELAY_W-1:0]    w_rd_delay;
    logic [NUM_INPUTS-1:0] w_rd_mask;
    logic [c_DW-1:0]       w_rd_data;
    logic [c_DW-1:0]       w_masked;
    logic [DELAY_W-1:0]    w_cur;
    logic [c_LW-1:0]       w_len_clamp;
    logic                  w_last;

    assign w_mem_we   = bus.wr_en && (r_state_q == S_IDLE);
    assign w_wr_entry = {bus.wr_delay, bus.wr_mask, bus.wr_data};
    assign {w_rd_delay, w_rd_mask, w_rd_data} = w_rd_entry;

    trace_mem #(
        .WIDTH (c_EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (bus.wr_addr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_idx_q),
        .o_rdata (w_rd_entry)
    );

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_mask
        assign w_masked[g*DATA_W +: DATA_W] = w_rd_mask[g] ? w_rd_data[g*DATA_W +: DATA_W] : '0;
    end

    // The read data is only valid from the first WAIT cycle, so the countdown
    // is seeded from it there instead of on the FETCH->WAIT edge.
    assign w_cur       = r_cnt_ld_q ? r_cnt_q : ((w_rd_delay == '0) ? c_ONE : w_rd_delay);
    assign w_len_clamp = (num_entries > c_DEPTH_LEN) ? c_DEPTH_LEN : num_entries;
    assign w_last      = (({1'b0, r_idx_q} + c_LW'(1)) == r_len_q);

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_len_d    = r_len_q;
        w_loop_d   = r_loop_q;
        w_cnt_d    = r_cnt_q;
        w_cnt_ld_d = r_cnt_ld_q;
        w_new_d    = '0;
        w_data_d   = '0;
        w_done_d   = 1'b0;
        w_wr_err_d = bus.wr_en && (r_state_q != S_IDLE);
        w_ccnt_d   = r_ccnt_q;
        if ((r_state_q != S_IDLE) && (r_ccnt_q != '1)) begin
            w_ccnt_d = r_ccnt_q + CNT_W'(1);
        end

        case (r_state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    w_ccnt_d = '0;
                    w_len_d  = w_len_clamp;
                    w_loop_d = loop;
                    w_idx_d  = '0;
                    if (w_len_clamp == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                w_cnt_ld_d = 1'b0;
                w_state_d  = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_ld_d = 1'b1;
                if (hold) begin
                    w_cnt_d = w_cur;
                end else if (w_cur == c_ONE) begin
                    w_state_d = S_FIRE;
                    w_new_d   = w_rd_mask;
                    w_data_d  = w_masked;
                end else begin
                    w_cnt_d = w_cur - c_ONE;
                end
            end
            S_FIRE: begin
                if (w_last && !r_loop_q) begin
                    w_state_d = S_IDLE;
                    w_done_d  = 1'b1;
                    w_idx_d   = '0;
                end else begin
                    w_state_d = S_FETCH;
                    w_idx_d   = w_last ? '0 : r_idx_q + c_AW'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (stop && (r_state_q != S_IDLE)) begin
            w_state_d = S_IDLE;
            w_idx_d   = '0;
            w_new_d   = '0;
            w_data_d  = '0;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= S_IDLE;
            r_idx_q    <= '0;
            r_len_q    <= '0;
            r_loop_q   <= 1'b0;
            r_cnt_q    <= '0;
            r_cnt_ld_q <= 1'b0;
            r_new_q    <= '0;
            r_data_q   <= '0;
            r_done_q   <= 1'b0;
            r_wr_err_q <= 1'b0;
            r_ccnt_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_len_q    <= w_len_d;
            r_loop_q   <= w_loop_d;
            r_cnt_q    <= w_cnt_d;
            r_cnt_ld_q <= w_cnt_ld_d;
            r_new_q    <= w_new_d;
            r_data_q   <= w_data_d;
            r_done_q   <= w_done_d;
            r_wr_err_q <= w_wr_err_d;
            r_ccnt_q   <= w_ccnt_d;
        end
    end

    assign bus.input_data = r_data_q;
    assign bus.new_input  = r_new_q;
    assign bus.wr_err     = r_wr_err_q;
    assign busy           = (r_state_q != S_IDLE);
    assign done           = r_done_q;
    assign entry_idx      = r_idx_q;
    assign cycle_count    = r_ccnt_q;

endmodule
`default_nettype wire
